// File: rtl/native_delay_sweeper.sv
// native_delay_sweeper: walks the delay-core tap register from start to stop
// over the native bus, verifying each write by readback and strobing a sample
// once the tap has settled for the programmed dwell.
// Ports: NATIVE_CLK/NATIVE_RST clock and async reset; start/abort controls;
// cfg_* sweep range, step and dwell; NATIVE_* bus master; busy, cur_tap,
// sample_strobe, done, error, err_code status.
module native_delay_sweeper #(
    parameter int NATIVE_ADDR_WDITH = 1,
    parameter int NATIVE_DATA_WIDTH = 9,
    parameter logic [NATIVE_ADDR_WDITH-1:0] TAP_ADDR = '0,
    parameter int DWELL_WIDTH = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                         NATIVE_CLK,
    input  logic                         NATIVE_RST,
    input  logic                         start,
    input  logic                         abort,
    input  logic [NATIVE_DATA_WIDTH-1:0] cfg_start_tap,
    input  logic [NATIVE_DATA_WIDTH-1:0] cfg_stop_tap,
    input  logic [NATIVE_DATA_WIDTH-1:0] cfg_step,
    input  logic [DWELL_WIDTH-1:0]       cfg_dwell,
    output logic                         NATIVE_EN,
    output logic                         NATIVE_WR,
    output logic [NATIVE_ADDR_WDITH-1:0] NATIVE_ADDR,
    output logic [NATIVE_DATA_WIDTH-1:0] NATIVE_DATA_IN,
    input  logic [NATIVE_DATA_WIDTH-1:0] NATIVE_DATA_OUT,
    input  logic                         NATIVE_READY,
    output logic                         busy,
    output logic [NATIVE_DATA_WIDTH-1:0] cur_tap,
    output logic                         sample_strobe,
    output logic                         done,
    output logic                         error,
    output logic [1:0]                   err_code
);

    localparam int DW = NATIVE_DATA_WIDTH;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, WR, RD, DWELL, SAMPLE, NEXT, FIN
    } state_t;

    state_t               state_q, state_d;
    logic                 en_q, en_d;
    logic [DW-1:0]        tap_q, tap_d;
    logic [DW-1:0]        stop_q, stop_d;
    logic [DW-1:0]        step_q, step_d;
    logic [DWELL_WIDTH-1:0] dcfg_q, dcfg_d;
    logic [DWELL_WIDTH-1:0] dcnt_q, dcnt_d;
    logic [TW-1:0]        tmo_q, tmo_d;
    logic                 abort_q, abort_d;
    logic                 err_q, err_d;
    logic [1:0]           code_q, code_d;

    logic                 rdy;
    logic                 tmo_hit;
    logic                 stop_req;
    logic [DW:0]          nxt;

    // READY only counts while we own the bus; a stray pulse is dropped.
    assign rdy      = en_q & NATIVE_READY;
    assign tmo_hit  = en_q & ~NATIVE_READY & (tmo_q == TLAST);
    assign stop_req = abort | abort_q;
    assign nxt      = {1'b0, tap_q} + {1'b0, step_q};

    always_ff @(posedge NATIVE_CLK or posedge NATIVE_RST) begin
        if (NATIVE_RST) begin
            state_q <= IDLE;
            en_q    <= 1'b0;
            tap_q   <= '0;
            stop_q  <= '0;
            step_q  <= '0;
            dcfg_q  <= '0;
            dcnt_q  <= '0;
            tmo_q   <= '0;
            abort_q <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            tap_q   <= tap_d;
            stop_q  <= stop_d;
            step_q  <= step_d;
            dcfg_q  <= dcfg_d;
            dcnt_q  <= dcnt_d;
            tmo_q   <= tmo_d;
            abort_q <= abort_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end

    always_comb begin
        state_d = state_q;
        en_d    = en_q;
        tap_d   = tap_q;
        stop_d  = stop_q;
        step_d  = step_q;
        dcfg_d  = dcfg_q;
        dcnt_d  = dcnt_q;
        tmo_d   = en_q ? tmo_q + 1'b1 : '0;
        // An abort seen mid-transaction is remembered until it can be honoured.
        abort_d = abort_q | (abort & (state_q != IDLE));
        err_d   = err_q;
        code_d  = code_q;

        unique case (state_q)
            IDLE: begin
                abort_d = 1'b0;
                if (start) begin
                    stop_d = cfg_stop_tap;
                    step_d = cfg_step;
                    dcfg_d = cfg_dwell;
                    err_d  = 1'b0;
                    code_d = 2'd0;
                    if (cfg_step == '0 || cfg_start_tap > cfg_stop_tap) begin
                        err_d   = 1'b1;
                        code_d  = 2'd1;
                        state_d = FIN;
                    end else begin
                        tap_d   = cfg_start_tap;
                        en_d    = 1'b1;
                        state_d = WR;
                    end
                end
            end
            WR: begin
                if (rdy) begin
                    en_d    = 1'b0;
                    state_d = RD;
                end else if (tmo_hit) begin
                    en_d    = 1'b0;
                    err_d   = 1'b1;
                    code_d  = 2'd2;
                    state_d = FIN;
                end
            end
            RD: begin
                // First RD cycle keeps EN low to separate it from the write.
                if (!en_q) begin
                    en_d = 1'b1;
                end else if (rdy) begin
                    en_d = 1'b0;
                    if (NATIVE_DATA_OUT != tap_q) begin
                        err_d   = 1'b1;
                        code_d  = 2'd3;
                        state_d = FIN;
                    end else if (stop_req) begin
                        state_d = FIN;
                    end else if (dcfg_q == '0) begin
                        state_d = SAMPLE;
                    end else begin
                        dcnt_d  = dcfg_q;
                        state_d = DWELL;
                    end
                end else if (tmo_hit) begin
                    en_d    = 1'b0;
                    err_d   = 1'b1;
                    code_d  = 2'd2;
                    state_d = FIN;
                end
            end
            DWELL: begin
                if (stop_req) begin
                    state_d = FIN;
                end else if (dcnt_q <= DWELL_WIDTH'(1)) begin
                    state_d = SAMPLE;
                end else begin
                    dcnt_d = dcnt_q - 1'b1;
                end
            end
            SAMPLE: begin
                state_d = stop_req ? FIN : NEXT;
            end
            NEXT: begin
                if (stop_req || nxt > {1'b0, stop_q}) begin
                    state_d = FIN;
                end else begin
                    tap_d   = nxt[DW-1:0];
                    en_d    = 1'b1;
                    state_d = WR;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                en_d    = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    assign NATIVE_EN      = en_q;
    assign NATIVE_WR      = en_q & (state_q == WR);
    assign NATIVE_ADDR    = en_q ? TAP_ADDR : '0;
    assign NATIVE_DATA_IN = (state_q == WR) ? tap_q : '0;
    assign busy           = (state_q != IDLE);
    assign cur_tap        = tap_q;
    assign sample_strobe  = (state_q == SAMPLE);
    assign done           = (state_q == FIN);
    assign error          = err_q;
    assign err_code       = code_q;

endmodule
